// File: rtl/des_job_sched_if.sv
// -----------------------------------------------------------------------------
// des_job_sched_if
// Byte-stream link between the job scheduler and the UART.
//   rx_valid : one-cycle strobe, rx_byte carries a received byte
//   rx_byte  : received byte
//   tx_byte  : byte offered to the UART transmitter
//   tx_valid : tx_byte valid; a transfer happens when tx_valid and tx_ready
//   tx_ready : transmitter can accept a byte
// Modports:
//   slave  : the scheduler side (consumes rx, produces tx)
//   master : the UART / environment side
// -----------------------------------------------------------------------------
interface des_job_sched_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport slave (
    input  rx_valid,
    input  rx_byte,
    input  tx_ready,
    output tx_byte,
    output tx_valid
  );

  modport master (
    output rx_valid,
    output rx_byte,
    output tx_ready,
    input  tx_byte,
    input  tx_valid
  );
endinterface

// File: rtl/des_job_sched.sv
// -----------------------------------------------------------------------------
// des_job_sched
// Command-driven front end for an external DES core fed from a UART.
//   'E' + 8 bytes : encrypt one 64-bit block, result sent back as 8 bytes
//   'D' + 8 bytes : decrypt one 64-bit block, result sent back as 8 bytes
//   'K' + 7 bytes : load a new 56-bit key (nothing is transmitted)
// Any other byte in IDLE is ignored. Bytes arriving while a job is in WAIT
// or SEND are dropped and flagged on the sticky overrun output.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   uart         : byte stream (rx strobe in, tx valid/ready out)
//   des_in       : block presented to the DES core
//   des_key      : active key (only ever shows complete keys)
//   des_decrypt  : 0 = encrypt, 1 = decrypt
//   des_out      : DES core result, sampled on the last WAIT cycle
//   busy         : high whenever the FSM is not IDLE
//   overrun      : sticky dropped-byte flag, cleared only by reset
//   block_count  : completed result frames, wraps at 16 bits
// BLOCK_COUNT_INIT is the reset value of block_count; leave at 0 for
// normal use, a non-zero value lets an instance start near the wrap point.
// -----------------------------------------------------------------------------
module des_job_sched #(
  parameter int unsigned DES_LATENCY      = 16,
  parameter logic [55:0] KEY_INIT         = 56'hcab00d1ecab00d,
  parameter logic [15:0] BLOCK_COUNT_INIT = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  des_job_sched_if.slave        uart,
  output logic [63:0]           des_in,
  output logic [55:0]           des_key,
  output logic                  des_decrypt,
  input  logic [63:0]           des_out,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           block_count
);

  localparam logic [7:0] CMD_ENC   = 8'h45;
  localparam logic [7:0] CMD_DEC   = 8'h44;
  localparam logic [7:0] CMD_KEY   = 8'h4B;
  // WAIT runs while the down-counter steps from DES_LATENCY-1 to 0.
  localparam logic [7:0] WAIT_LOAD = 8'(DES_LATENCY - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_KEY  = 3'd2,
    ST_WAIT = 3'd3,
    ST_SEND = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic        mode_r;
  logic [63:0] block_r;
  logic [47:0] key_stage_r;
  logic [55:0] key_r;
  logic [2:0]  byte_cnt_r;
  logic [7:0]  wait_cnt_r;
  logic [63:0] out_r;
  logic [2:0]  tx_cnt_r;
  logic        tx_valid_r;
  logic        busy_r;
  logic        overrun_r;
  logic [15:0] block_count_r;

  logic        rx_s;
  logic [7:0]  byte_s;
  logic        in_idle_s;
  logic        cmd_enc_s;
  logic        cmd_dec_s;
  logic        cmd_key_s;
  logic        data_byte_s;
  logic        key_byte_s;
  logic        last_data_s;
  logic        last_key_s;
  logic        wait_done_s;
  logic        xfer_s;
  logic        last_xfer_s;
  logic        drop_s;

  assign rx_s   = uart.rx_valid;
  assign byte_s = uart.rx_byte;

  // Event decode shared by the FSM and the datapath registers.
  always_comb begin
    in_idle_s   = (state_r == ST_IDLE);
    cmd_enc_s   = in_idle_s && rx_s && (byte_s == CMD_ENC);
    cmd_dec_s   = in_idle_s && rx_s && (byte_s == CMD_DEC);
    cmd_key_s   = in_idle_s && rx_s && (byte_s == CMD_KEY);
    data_byte_s = (state_r == ST_DATA) && rx_s;
    key_byte_s  = (state_r == ST_KEY) && rx_s;
    last_data_s = data_byte_s && (byte_cnt_r == 3'd7);
    last_key_s  = key_byte_s && (byte_cnt_r == 3'd6);
    wait_done_s = (state_r == ST_WAIT) && (wait_cnt_r == 8'd0);
    // tx_valid_r is high exactly while in SEND, so this is the transfer.
    xfer_s      = tx_valid_r && uart.tx_ready;
    last_xfer_s = xfer_s && (tx_cnt_r == 3'd7);
    // A strobe during WAIT or SEND (including the final transfer) is lost.
    drop_s      = rx_s && ((state_r == ST_WAIT) || (state_r == ST_SEND));
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_enc_s || cmd_dec_s) begin
          state_s = ST_DATA;
        end else if (cmd_key_s) begin
          state_s = ST_KEY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (last_data_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_KEY: begin
        if (last_key_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_KEY;
        end
      end
      ST_WAIT: begin
        if (wait_done_s) begin
          state_s = ST_SEND;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SEND: begin
        if (last_xfer_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SEND;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status flags registered from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      tx_valid_r <= 1'b0;
    end else begin
      busy_r     <= (state_s != ST_IDLE);
      tx_valid_r <= (state_s == ST_SEND);
    end
  end

  // Mode register: written only by an accepted E/D command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
    end else if (cmd_enc_s) begin
      mode_r <= 1'b0;
    end else if (cmd_dec_s) begin
      mode_r <= 1'b1;
    end
  end

  // Shared DATA/KEY byte counter, cleared on every command that enters them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_r <= 3'd0;
    end else if (cmd_enc_s || cmd_dec_s || cmd_key_s) begin
      byte_cnt_r <= 3'd0;
    end else if (data_byte_s || key_byte_s) begin
      byte_cnt_r <= byte_cnt_r + 3'd1;
    end
  end

  // Block register: bytes shift in from the bottom so the first lands on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_r <= 64'h0;
    end else if (data_byte_s) begin
      block_r <= {block_r[55:0], byte_s};
    end
  end

  // Key staging and active key; the active key is written in one step with
  // the 7th byte so a partial key never reaches des_key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_stage_r <= 48'h0;
      key_r       <= KEY_INIT;
    end else if (last_key_s) begin
      key_r       <= {key_stage_r, byte_s};
    end else if (key_byte_s) begin
      key_stage_r <= {key_stage_r[39:0], byte_s};
    end
  end

  // WAIT down-counter, armed by the 8th data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 8'd0;
    end else if (last_data_s) begin
      wait_cnt_r <= WAIT_LOAD;
    end else if ((state_r == ST_WAIT) && (wait_cnt_r != 8'd0)) begin
      wait_cnt_r <= wait_cnt_r - 8'd1;
    end
  end

  // Result shifter: captures des_out at the end of WAIT and advances one
  // byte per transfer; the top byte is what the transmitter sees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r    <= 64'h0;
      tx_cnt_r <= 3'd0;
    end else if (wait_done_s) begin
      out_r    <= des_out;
      tx_cnt_r <= 3'd0;
    end else if (xfer_s) begin
      out_r    <= {out_r[55:0], 8'h00};
      tx_cnt_r <= tx_cnt_r + 3'd1;
    end
  end

  // Sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end
  end

  // Completed-frame counter, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_count_r <= BLOCK_COUNT_INIT;
    end else if (last_xfer_s) begin
      block_count_r <= block_count_r + 16'd1;
    end
  end

  assign uart.tx_valid = tx_valid_r;
  assign uart.tx_byte  = out_r[63:56];
  assign des_in        = block_r;
  assign des_key       = key_r;
  assign des_decrypt   = mode_r;
  assign busy          = busy_r;
  assign overrun       = overrun_r;
  assign block_count   = block_count_r;

endmodule

// File: tb/tb_des_job_sched.sv
// -----------------------------------------------------------------------------
// tb_des_job_sched
// Directed bench for des_job_sched. A simple reversible XOR function stands in
// for the DES core. A second instance, reset to block_count=0xFFFF, sees the
// same traffic so the counter wrap shows on its first completed frame.
// -----------------------------------------------------------------------------
module tb_des_job_sched;
  localparam int          LAT   = 8;
  localparam logic [55:0] KINIT = 56'hcab00d1ecab00d;

  logic clk;
  logic rst_n;

  des_job_sched_if bus();
  des_job_sched_if wbus();

  logic [63:0] des_in, des_out, w_des_in, w_des_out;
  logic [55:0] des_key, w_des_key;
  logic        des_decrypt, w_des_decrypt;
  logic        busy, w_busy, overrun, w_overrun;
  logic [15:0] block_count, w_block_count;

  int errors = 0;
  int checks = 0;
  int xfer_total = 0;
  int tx_high_total = 0;

  function automatic logic [63:0] des_model(input logic [63:0] blk,
                                            input logic [55:0] key,
                                            input logic dec);
    if (dec) des_model = blk ^ {key, 8'h5A};
    else     des_model = ~(blk ^ {key, 8'hA5});
  endfunction

  assign des_out   = des_model(des_in, des_key, des_decrypt);
  assign w_des_out = des_model(w_des_in, w_des_key, w_des_decrypt);

  assign wbus.rx_valid = bus.rx_valid;
  assign wbus.rx_byte  = bus.rx_byte;
  assign wbus.tx_ready = bus.tx_ready;

  des_job_sched #(.DES_LATENCY(LAT), .KEY_INIT(KINIT)) dut (
    .clk(clk), .rst_n(rst_n), .uart(bus.slave),
    .des_in(des_in), .des_key(des_key), .des_decrypt(des_decrypt),
    .des_out(des_out), .busy(busy), .overrun(overrun), .block_count(block_count)
  );

  des_job_sched #(.DES_LATENCY(LAT), .KEY_INIT(KINIT),
                  .BLOCK_COUNT_INIT(16'hFFFF)) wrap_dut (
    .clk(clk), .rst_n(rst_n), .uart(wbus.slave),
    .des_in(w_des_in), .des_key(w_des_key), .des_decrypt(w_des_decrypt),
    .des_out(w_des_out), .busy(w_busy), .overrun(w_overrun),
    .block_count(w_block_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.tx_valid && bus.tx_ready) xfer_total <= xfer_total + 1;
    if (bus.tx_valid) tx_high_total <= tx_high_total + 1;
  end

  // Strobe one byte across the next rising edge; returns on the following
  // falling edge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [63:0] blk);
    send_byte(cmd);
    for (int i = 0; i < 8; i++) send_byte(blk[63-8*i -: 8]);
  endtask

  task automatic wait_tx(output int cycles);
    cycles = 0;
    while (bus.tx_valid !== 1'b1 && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (bus.tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_tx: tx_valid=%b after %0d cycles, required 1", bus.tx_valid, cycles);
    end
  endtask

  // Take 8 bytes with tx_ready=1; optionally strobe a byte on the last one.
  task automatic collect_frame(input logic [63:0] exp, input logic strobe_last);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_byte !== exp[63-8*k -: 8]) begin
        errors++;
        $display("FAIL tx_byte[%0d]: got valid=%b byte=%h, required valid=1 byte=%h",
                 k, bus.tx_valid, bus.tx_byte, exp[63-8*k -: 8]);
      end
      if (strobe_last && k == 7) begin
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h4B;
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
    checks++;
    if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: tx_valid=%b busy=%b, required 0 0", bus.tx_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b required 0", bus.tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b required 0", overrun); end
    checks++; if (des_decrypt !== 1'b0) begin errors++; $display("FAIL rst_decrypt: got %b required 0", des_decrypt); end
    checks++; if (block_count !== 16'h0000) begin errors++; $display("FAIL rst_count: got %h required 0000", block_count); end
    checks++; if (des_in !== 64'h0) begin errors++; $display("FAIL rst_des_in: got %h required 0", des_in); end
    checks++; if (bus.tx_byte !== 8'h00) begin errors++; $display("FAIL rst_tx_byte: got %h required 00", bus.tx_byte); end
    checks++; if (des_key !== KINIT) begin errors++; $display("FAIL rst_key: got %h required %h", des_key, KINIT); end
    checks++; if (w_block_count !== 16'hFFFF) begin errors++; $display("FAIL rst_wrap_count: got %h required ffff", w_block_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_encrypt();
    logic [63:0] blk;
    int n;
    blk = 64'h0123456789ABCDEF;
    send_frame(8'h45, blk);
    checks++; if (des_in !== blk) begin errors++; $display("FAIL enc_des_in: got %h required %h", des_in, blk); end
    checks++; if (des_decrypt !== 1'b0) begin errors++; $display("FAIL enc_mode: got %b required 0", des_decrypt); end
    checks++; if (busy !== 1'b1 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL enc_wait_flags: busy=%b tx_valid=%b required 1 0", busy, bus.tx_valid); end
    wait_tx(n);
    checks++; if (n != LAT) begin errors++; $display("FAIL enc_latency: got %0d cycles required %0d", n, LAT); end
    collect_frame(des_model(blk, KINIT, 1'b0), 1'b0);
    checks++; if (block_count !== 16'd1) begin errors++; $display("FAIL enc_count: got %h required 0001", block_count); end
    checks++; if (w_block_count !== 16'h0000 || w_busy !== 1'b0) begin errors++; $display("FAIL wrap_count: got %h busy=%b required 0000 0", w_block_count, w_busy); end
  endtask

  task automatic test_back_pressure();
    logic [63:0] blk;
    logic [63:0] exp;
    int n, base, stable;
    blk = 64'hFEDCBA9876543210;
    exp = des_model(blk, KINIT, 1'b0);
    send_frame(8'h45, blk);
    wait_tx(n);
    base = xfer_total;
    repeat (2) @(negedge clk);
    bus.tx_ready = 1'b0;
    stable = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_valid === 1'b1 && bus.tx_byte === exp[47:40]) stable++;
    end
    checks++; if (stable != 20) begin errors++; $display("FAIL bp_stable: got %0d stable cycles required 20", stable); end
    bus.tx_ready = 1'b1;
    n = 0;
    while (bus.tx_valid === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (xfer_total - base != 8) begin errors++; $display("FAIL bp_transfers: got %0d required 8", xfer_total - base); end
    checks++; if (block_count !== 16'd2) begin errors++; $display("FAIL bp_count: got %h required 0002", block_count); end
  endtask

  task automatic test_key();
    logic [55:0] kb;
    int base;
    kb = 56'h11223344556677;
    base = tx_high_total;
    send_byte(8'h4B);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL key_busy: got %b required 1", busy); end
    for (int i = 0; i < 6; i++) send_byte(kb[55-8*i -: 8]);
    checks++; if (des_key !== KINIT) begin errors++; $display("FAIL key_partial: got %h required %h", des_key, KINIT); end
    send_byte(kb[7:0]);
    checks++; if (des_key !== kb) begin errors++; $display("FAIL key_load: got %h required %h", des_key, kb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL key_idle: busy=%b required 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (tx_high_total != base) begin errors++; $display("FAIL key_no_tx: got %0d tx_valid cycles required 0", tx_high_total - base); end
    checks++; if (block_count !== 16'd2) begin errors++; $display("FAIL key_count: got %h required 0002", block_count); end
  endtask

  task automatic test_overrun();
    logic [63:0] blk;
    int n;
    blk = 64'h0011223344556677;
    send_byte(8'h00);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL garbage_busy: got %b required 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL garbage_overrun: got %b required 0", overrun); end
    send_frame(8'h45, blk);
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_byte = 8'h4B;
    @(negedge clk); bus.rx_byte = 8'h44;
    @(negedge clk); bus.rx_byte = 8'h45;
    @(negedge clk); bus.rx_valid = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b required 1", overrun); end
    checks++; if (des_in !== blk || des_decrypt !== 1'b0) begin errors++; $display("FAIL ovr_datapath: des_in=%h mode=%b required %h 0", des_in, des_decrypt, blk); end
    wait_tx(n);
    collect_frame(des_model(blk, 56'h11223344556677, 1'b0), 1'b1);
    checks++; if (block_count !== 16'd3 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_end: count=%h overrun=%b required 0003 1", block_count, overrun); end
  endtask

  task automatic test_reset_mid_send();
    logic [63:0] blk;
    logic [63:0] blk2;
    int n, base;
    blk  = 64'h89ABCDEF01234567;
    blk2 = 64'hA5A55A5A0F0FF0F0;
    send_frame(8'h45, blk);
    wait_tx(n);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_valid: got %b required 0", bus.tx_valid); end
    checks++; if (des_key !== KINIT) begin errors++; $display("FAIL mid_rst_key: got %h required %h", des_key, KINIT); end
    checks++; if (overrun !== 1'b0 || block_count !== 16'h0000) begin errors++; $display("FAIL mid_rst_status: overrun=%b count=%h required 0 0000", overrun, block_count); end
    base = tx_high_total;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx_high_total != base || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_quiet: tx cycles=%0d busy=%b required 0 0", tx_high_total - base, busy); end
    send_frame(8'h44, blk2);
    checks++; if (des_decrypt !== 1'b1) begin errors++; $display("FAIL dec_mode: got %b required 1", des_decrypt); end
    wait_tx(n);
    collect_frame(des_model(blk2, KINIT, 1'b1), 1'b0);
    checks++; if (block_count !== 16'd1) begin errors++; $display("FAIL dec_count: got %h required 0001", block_count); end
    checks++; if (w_overrun !== 1'b0) begin errors++; $display("FAIL wrap_overrun: got %b required 0", w_overrun); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.tx_ready = 1'b1;
    test_reset();
    test_encrypt();
    test_back_pressure();
    test_key();
    test_overrun();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_job_sched.md
DES_JOB_SCHED -- requirements
Module: des_job_sched

Interface
REQ-001 Parameter DES_LATENCY, default 16: clock cycles from a stable des_in/des_decrypt/des_key to a valid des_out; legal range 1..255.
REQ-002 Parameter KEY_INIT, default 56'hcab00d1ecab00d: DES key value after reset.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous active-low reset.
REQ-005 Port rx_valid  input  1: one-cycle strobe; rx_byte holds a received UART byte.
REQ-006 Port rx_byte  input  8: received byte.
REQ-007 Port tx_byte  output  8: byte offered to the UART transmitter.
REQ-008 Port tx_valid  output  1: tx_byte valid; a transfer occurs on any cycle with tx_valid=1 and tx_ready=1.
REQ-009 Port tx_ready  input  1: UART transmitter can accept a byte.
REQ-010 Port des_in  output  64: block presented to the DES core.
REQ-011 Port des_key  output  56: active key.
REQ-012 Port des_decrypt  output  1: 0 = encrypt, 1 = decrypt.
REQ-013 Port des_out  input  64: DES core result.
REQ-014 Port busy  output  1: high in every state except IDLE.
REQ-015 Port overrun  output  1: sticky flag; set when a byte is dropped.
REQ-016 Port block_count  output  16: count of completed result frames; wraps from 0xFFFF to 0.

Function
REQ-017 The FSM SHALL have the states IDLE, DATA, KEY, WAIT and SEND.
REQ-018 In IDLE, a byte 0x45 ('E') SHALL clear the mode register to 0 and go to DATA.
REQ-019 In IDLE, a byte 0x44 ('D') SHALL set the mode register to 1 and go to DATA.
REQ-020 In IDLE, a byte 0x4B ('K') SHALL go to KEY.
REQ-021 In IDLE, any other byte SHALL be discarded silently; the state stays IDLE and overrun is unchanged.
REQ-022 In DATA, each of the next 8 bytes SHALL be shifted into a 64-bit block register, first byte landing in bits [63:56].
REQ-023 After the 8th DATA byte is accepted, the next cycle SHALL enter WAIT, and des_in SHALL show the complete block from that cycle onward.
REQ-024 des_decrypt SHALL reflect the mode register, and mode SHALL change only on a command byte accepted in IDLE.
REQ-025 WAIT SHALL last exactly DES_LATENCY cycles, counted by an 8-bit down-counter.
REQ-026 On the last WAIT cycle, des_out SHALL be captured into a 64-bit output shift register and the FSM SHALL go to SEND.
REQ-027 SEND SHALL present output bytes MSB first; tx_valid SHALL be 1 throughout SEND and 0 in every other state.
REQ-028 tx_byte SHALL advance to the next byte only on a transfer; tx_byte and tx_valid SHALL stay stable while tx_ready=0.
REQ-029 On the 8th transfer, block_count SHALL increment and the next cycle SHALL be IDLE with tx_valid=0.
REQ-030 In KEY, 7 bytes SHALL be shifted into a staging register, first byte landing in bits [55:48].
REQ-031 des_key SHALL update atomically on the cycle after the 7th KEY byte, then the FSM SHALL return to IDLE; a partial key SHALL never be visible on des_key.
REQ-032 A key load SHALL transmit nothing and SHALL not change block_count.
REQ-033 An rx_valid strobe in WAIT or SEND SHALL drop the byte, set overrun, and leave the FSM and datapath unaffected.
REQ-034 overrun SHALL clear only on reset.
REQ-035 Byte counters SHALL be 3-bit and SHALL be reset on every entry to DATA or KEY.
REQ-036 A strobe coincident with the final transfer in SEND SHALL be treated as overrun, not as a command.

Reset
REQ-037 While rst_n=0, the FSM SHALL be IDLE and tx_valid, busy, overrun, des_decrypt SHALL be 0.
REQ-038 While rst_n=0, block_count, des_in, tx_byte and all counters SHALL be 0.
REQ-039 While rst_n=0, des_key SHALL equal KEY_INIT.
REQ-040 Reset asserted mid-frame, in any state, SHALL abandon the frame without emitting any further tx_valid.
REQ-041 The first byte after rst_n deasserts SHALL be decoded in IDLE.

Verification
REQ-042 Encrypt frame: 'E' followed by 01 23 45 67 89 AB CD EF, tx_ready=1 -> des_in=0x0123456789ABCDEF and des_decrypt=0; after DES_LATENCY cycles, the 8 bytes of des_out are sent MSB first; block_count=1.
REQ-043 Back-pressure: hold tx_ready=0 for 20 cycles during SEND -> tx_byte and tx_valid stay stable for those cycles; exactly 8 transfers complete afterwards.
REQ-044 Key load: 'K' followed by 11 22 33 44 55 66 77 -> des_key=0x11223344556677 on the cycle after the last byte; no tx_valid pulse occurs.
REQ-045 Overrun and garbage: send 3 bytes during WAIT -> overrun=1 and the result frame is unchanged; byte 0x00 sent in IDLE -> ignored, overrun unchanged.
REQ-046 Reset mid-SEND: assert rst_n=0 after the 3rd transfer -> tx_valid=0 and des_key=KEY_INIT; a following 'D' frame completes with des_decrypt=1.
REQ-047 Counter wrap: preload block_count to 0xFFFF and complete one frame -> block_count=0x0000.
